wb_commit: RTL and testbench
============================

# wb_commit

Writeback commit stage for the scalar pipeline. It collects results from the scalar ALU and the load/store unit, buffers them per source, and arbitrates them onto the single register-file write port (`commit_rd`/`commit_data`). It issues at most one register write per cycle, and each write pulse clears the register-file scoreboard bit for that destination. `commit_rd == 0` means no write this cycle, which is the register file's idle encoding.

## Interface
Parameters:
- `DEPTH`, default 2: entries per source FIFO; power of two, ≥ 2.
- `XLEN`, default 32: data width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state freezes.
- `alu_valid` in 1: ALU result offered.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in XLEN: ALU result.
- `alu_ready` out 1: ALU FIFO can accept.
- `lsu_valid` in 1: load result offered.
- `lsu_rd` in 5: load destination register.
- `lsu_data` in XLEN: load data.
- `lsu_ready` out 1: LSU FIFO can accept.
- `commit_rd` out 5: register-file write address; 0 means idle.
- `commit_data` out XLEN: register-file write data.

## Operation
- **Acceptance:** a result is accepted on a rising edge where `valid && ready && rdy`.
- **`rd == 0` results:** accepted and discarded. They are never enqueued and never produce a commit.
- **FIFOs:** one FIFO per source, depth `DEPTH`, with a count register.
  - `*_ready = (count < DEPTH)`, taken from the registered count.
  - There is no same-cycle pass-through when the FIFO is full, even if a pop occurs in that cycle.
- **Per-cycle arbitration (when `rdy` is high):** candidates are the head of each non-empty FIFO.
  - If the FIFO is empty, the same-cycle input (`valid && rd != 0`) is the candidate instead (fall-through).
- **Grant:** the granted candidate is loaded into the output register `{commit_rd, commit_data}`.
  - Its FIFO is popped, or the fall-through input is consumed without being enqueued.
  - The losing same-cycle input is enqueued normally.
- **Idle:** if no candidate exists, the output register loads `commit_rd = 0` and `commit_data = 0`.
- **One-cycle pulse:** each accepted non-zero result appears on `commit_rd` for exactly one cycle.
  - A repeated pulse would wrongly clear a busy bit set by a later issue.
- **Ordering:**
  - Results from the same source commit in acceptance order.
  - There is no ordering between the two sources.
- **`rdy` low:** FIFOs, counts, the arbitration pointer and the output register all hold. `*_ready` keeps its registered value but no handshake completes.
- **Reset:** FIFOs empty, `commit_rd = 0`, `commit_data = 0`, `alu_ready = lsu_ready = 1`, round-robin pointer set to ALU.
  - Reset mid-operation drops all buffered results.

## Timing
- **Latency:** result accepted at edge N with its FIFO empty and the grant won → `commit_rd` valid during cycle N+1.
- **Losing or queued results:** commit on the first later cycle they win, one cycle after that win.
- **Throughput:** one commit per cycle sustained. Two simultaneous sources produce commits in back-to-back cycles.
- **Ready behaviour:**
  - `*_ready` is registered and deasserts the cycle after the count reaches `DEPTH`.
  - It reasserts the cycle after a pop.
- **Combinational paths:** no combinational path from any input to `commit_*` or `*_ready`.

## Configuration
- Macro `WB_RR_EN`.
- **Defined:** round-robin arbitration. After any grant, the pointer moves to the non-granted source, so neither source waits more than one commit when both are pending.
- **Undefined:** fixed priority, LSU over ALU.
  - The pointer register is not built.
  - An ALU result may wait indefinitely under continuous LSU traffic.
  - The LSU itself cannot be starved.

## Structure
- **`const.v`:** holds `REG_ADDR_W` (5) and `XLEN` (32), plus the `REG_ZERO` encoding.
- **Sub-module `wb_fifo`:** instantiated twice (ALU, LSU).
  - Contents: storage, head/tail pointers that wrap modulo `DEPTH`, count, registered `ready`, and peek/pop/push ports.
  - Push and pop in the same cycle leave the count unchanged.
- **Top:** `wb_commit` holds the arbitration, fall-through logic and the output register.

## Test plan
- **Single ALU result:** reset, then one ALU result `rd = 5`, `data = 0x1234` → `commit_rd = 5`, `commit_data = 0x1234` for exactly one cycle, one cycle after acceptance; then `commit_rd = 0`.
- **Simultaneous sources:** ALU (`rd = 3`, `0xA`) and LSU (`rd = 7`, `0xB`) in the same cycle, macro undefined → `rd = 7` then `rd = 3` in consecutive cycles.
- **Fill and drain with ALU starved:** continuous LSU stream plus 3 ALU results, `DEPTH = 2`, macro undefined.
  - `alu_ready` drops after 2 ALU results are accepted.
  - No ALU commits until the LSU stream stops.
  - ALU results then drain in order.
- **Round-robin:** same continuous LSU stream plus 3 ALU results with `WB_RR_EN` defined → commits alternate LSU/ALU.
- **`rd = 0` discard:** `alu_rd = 0` accepted → no commit cycle produced and FIFO count unchanged.
- **Stall and reset:** `rdy` held low for 3 cycles with a commit pending → `commit_rd` holds its value and nothing is lost.
  - Then `rst` with 2 buffered entries → `commit_rd = 0` and both readies = 1 the next cycle.
  - No stale commit appears afterwards.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared constants and types for the writeback commit stage: register address
// width, default data width, the idle register encoding and source identifiers.
package wb_commit_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer: DEPTH entries of {rd, data}, wrapping head/tail
// pointers, an occupancy count and a registered ready flag.
module wb_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  output logic                  ready,
  output logic                  empty,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [XLEN-1:0]       head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count, count_nxt;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ready <= 1'b1;
    end else if (en) begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt < FULL);
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (en && push) begin
      rd_mem[tail]   <= push_rd;
      data_mem[tail] <= push_data;
    end
  end

  assign empty     = (count == '0);
  assign head_rd   = rd_mem[head];
  assign head_data = data_mem[head];

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: arbitrates buffered ALU and LSU results onto the single
// register-file write port. WB_RR_EN selects round-robin; default is LSU-first.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  output logic [REG_ADDR_W-1:0] commit_rd,
  output logic [XLEN-1:0]       commit_data
);

  logic                  alu_empty, lsu_empty;
  logic [REG_ADDR_W-1:0] alu_head_rd, lsu_head_rd;
  logic [XLEN-1:0]       alu_head_data, lsu_head_data;
  logic                  alu_in, lsu_in, alu_cand, lsu_cand;
  logic                  grant_alu, grant_lsu;
  logic                  alu_push, alu_pop, lsu_push, lsu_pop;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_data;

`ifdef WB_RR_EN
  src_e rr_ptr;
`endif

  always_comb begin
    // rd == 0 results complete the handshake but are dropped here.
    alu_in   = rdy && alu_valid && alu_ready && (alu_rd != REG_ZERO);
    lsu_in   = rdy && lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);
    alu_cand = !alu_empty || alu_in;
    lsu_cand = !lsu_empty || lsu_in;
`ifdef WB_RR_EN
    grant_lsu = lsu_cand && (!alu_cand || rr_ptr == SRC_LSU);
`else
    grant_lsu = lsu_cand;
`endif
    grant_alu = alu_cand && !grant_lsu;

    alu_pop  = rdy && grant_alu && !alu_empty;
    lsu_pop  = rdy && grant_lsu && !lsu_empty;
    alu_push = alu_in && !(grant_alu && alu_empty);
    lsu_push = lsu_in && !(grant_lsu && lsu_empty);

    win_rd   = REG_ZERO;
    win_data = '0;
    if (grant_lsu) begin
      win_rd   = lsu_empty ? lsu_rd   : lsu_head_rd;
      win_data = lsu_empty ? lsu_data : lsu_head_data;
    end else if (grant_alu) begin
      win_rd   = alu_empty ? alu_rd   : alu_head_rd;
      win_data = alu_empty ? alu_data : alu_head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_rd   <= REG_ZERO;
      commit_data <= '0;
    end else if (rdy) begin
      commit_rd   <= win_rd;
      commit_data <= win_data;
    end
  end

`ifdef WB_RR_EN
  // After any grant the other source gets priority on the next contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= SRC_ALU;
    end else if (rdy && (grant_alu || grant_lsu)) begin
      rr_ptr <= grant_lsu ? SRC_ALU : SRC_LSU;
    end
  end
`endif

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .push      (alu_push),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (alu_pop),
    .ready     (alu_ready),
    .empty     (alu_empty),
    .head_rd   (alu_head_rd),
    .head_data (alu_head_data)
  );

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_lsu_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .push      (lsu_push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (lsu_pop),
    .ready     (lsu_ready),
    .empty     (lsu_empty),
    .head_rd   (lsu_head_rd),
    .head_data (lsu_head_data)
  );

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit (DEPTH=2). Expectations follow the build: LSU-first
// by default, alternating grants when WB_RR_EN is defined.
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, commit_rd;
  logic [31:0] alu_data, lsu_data, commit_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  wb_commit #(.DEPTH(2), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .commit_rd   (commit_rd),
    .commit_data (commit_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v;
    lsu_rd    = rd;
    lsu_data  = d;
  endtask

`ifdef WB_RR_EN
  localparam int N3 = 8;
  logic [4:0]  exp3_rd   [N3] = '{5'd16, 5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd0};
  logic [31:0] exp3_data [N3] = '{32'h100, 32'h21, 32'h101, 32'h22, 32'h102, 32'h23, 32'h103, 32'h0};
  logic        exp3_ardy [N3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [4:0]  exp4_rd   [5]  = '{5'd9, 5'd4, 5'd10, 5'd11, 5'd0};
  logic [31:0] exp4_data [5]  = '{32'h9, 32'h44, 32'ha, 32'hb, 32'h0};
`else
  localparam int N3 = 10;
  logic [4:0]  exp3_rd   [N3] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd1, 5'd2, 5'd3, 5'd0};
  logic [31:0] exp3_data [N3] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105,
                                  32'h21, 32'h22, 32'h23, 32'h0};
  logic        exp3_ardy [N3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [4:0]  exp4_rd   [5]  = '{5'd9, 5'd10, 5'd11, 5'd4, 5'd0};
  logic [31:0] exp4_data [5]  = '{32'h9, 32'ha, 32'hb, 32'h44, 32'h0};
`endif

  initial begin
    logic [4:0] first_rd, second_rd;

    // Reset state
    rst = 1'b1;
    rdy = 1'b1;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check("reset_commit_rd", 32'(commit_rd), 32'd0);
    check("reset_commit_data", commit_data, 32'h0);
    check("reset_alu_ready", 32'(alu_ready), 32'd1);
    check("reset_lsu_ready", 32'(lsu_ready), 32'd1);

    // Single ALU result: one-cycle pulse one cycle after acceptance
    drive_alu(1'b1, 5'd5, 32'h1234);
    step();
    check("single_rd", 32'(commit_rd), 32'd5);
    check("single_data", commit_data, 32'h1234);
    drive_alu(1'b0, 5'd0, 32'h0);
    step();
    check("single_idle_rd", 32'(commit_rd), 32'd0);
    check("single_idle_data", commit_data, 32'h0);

    // Simultaneous sources: LSU wins first in both builds here
    drive_alu(1'b1, 5'd3, 32'hA);
    drive_lsu(1'b1, 5'd7, 32'hB);
    step();
    check("simul_first_rd", 32'(commit_rd), 32'd7);
    check("simul_first_data", commit_data, 32'hB);
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    step();
    check("simul_second_rd", 32'(commit_rd), 32'd3);
    check("simul_second_data", commit_data, 32'hA);
    step();
    check("simul_idle_rd", 32'(commit_rd), 32'd0);

    // LSU stream plus three ALU results
    for (int k = 0; k < N3; k++) begin
`ifdef WB_RR_EN
      if (k < 4) drive_lsu(1'b1, 5'(16 + k), 32'h100 + 32'(k));
      else       drive_lsu(1'b0, 5'd0, 32'h0);
      if (k < 3) drive_alu(1'b1, 5'(1 + k), 32'h21 + 32'(k));
      else       drive_alu(1'b0, 5'd0, 32'h0);
`else
      if (k < 6) drive_lsu(1'b1, 5'(16 + k), 32'h100 + 32'(k));
      else       drive_lsu(1'b0, 5'd0, 32'h0);
      if (k == 0)      drive_alu(1'b1, 5'd1, 32'h21);
      else if (k == 1) drive_alu(1'b1, 5'd2, 32'h22);
      else if (k < 8)  drive_alu(1'b1, 5'd3, 32'h23);
      else             drive_alu(1'b0, 5'd0, 32'h0);
`endif
      step();
      check($sformatf("stream_rd_%0d", k), 32'(commit_rd), 32'(exp3_rd[k]));
      check($sformatf("stream_data_%0d", k), commit_data, exp3_data[k]);
      check($sformatf("stream_alu_ready_%0d", k), 32'(alu_ready), 32'(exp3_ardy[k]));
    end

    // rd == 0 discard: must not occupy an ALU FIFO slot
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive_lsu(1'b1, 5'(9 + k), 32'(9 + k));
      else       drive_lsu(1'b0, 5'd0, 32'h0);
      if (k == 0)      drive_alu(1'b1, 5'd0, 32'hDEAD);
      else if (k == 1) drive_alu(1'b1, 5'd4, 32'h44);
      else             drive_alu(1'b0, 5'd0, 32'h0);
      step();
      check($sformatf("rd0_rd_%0d", k), 32'(commit_rd), 32'(exp4_rd[k]));
      check($sformatf("rd0_data_%0d", k), commit_data, exp4_data[k]);
      check($sformatf("rd0_alu_ready_%0d", k), 32'(alu_ready), 32'd1);
    end

    // Stall: commit held for three cycles, offered input ignored
`ifdef WB_RR_EN
    first_rd  = 5'd6;
    second_rd = 5'd8;
`else
    first_rd  = 5'd8;
    second_rd = 5'd6;
`endif
    drive_alu(1'b1, 5'd6, 32'h66);
    drive_lsu(1'b1, 5'd8, 32'h88);
    step();
    check("stall_pre_rd", 32'(commit_rd), 32'(first_rd));
    rdy = 1'b0;
    drive_alu(1'b1, 5'd12, 32'hCC);
    drive_lsu(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_hold_rd_%0d", k), 32'(commit_rd), 32'(first_rd));
      check($sformatf("stall_hold_data_%0d", k), commit_data, (first_rd == 5'd6) ? 32'h66 : 32'h88);
    end
    rdy = 1'b1;
    drive_alu(1'b0, 5'd0, 32'h0);
    step();
    check("stall_post_rd", 32'(commit_rd), 32'(second_rd));
    check("stall_post_data", commit_data, (second_rd == 5'd6) ? 32'h66 : 32'h88);
    step();
    check("stall_idle_rd", 32'(commit_rd), 32'd0);

    // Reset with two buffered entries
    drive_alu(1'b1, 5'd13, 32'hD);
    drive_lsu(1'b1, 5'd14, 32'hE);
    step();
`ifdef WB_RR_EN
    check("prerst_rd_0", 32'(commit_rd), 32'd13);
`else
    check("prerst_rd_0", 32'(commit_rd), 32'd14);
`endif
    drive_alu(1'b1, 5'd15, 32'hF);
    drive_lsu(1'b1, 5'd16, 32'h10);
    step();
`ifdef WB_RR_EN
    check("prerst_rd_1", 32'(commit_rd), 32'd14);
    check("prerst_alu_ready", 32'(alu_ready), 32'd1);
`else
    check("prerst_rd_1", 32'(commit_rd), 32'd16);
    check("prerst_alu_ready", 32'(alu_ready), 32'd0);
`endif
    rst = 1'b1;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    step();
    check("rst_commit_rd", 32'(commit_rd), 32'd0);
    check("rst_commit_data", commit_data, 32'h0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("post_rst_rd_%0d", k), 32'(commit_rd), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
